// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative integer multiply/divide unit (RV64M-style MUL/DIV/DIVU/REM/REMU
//   and their W forms). Multiply is shift-add and divide is restoring. Both
//   retire one bit per cycle. Divide-by-zero, signed overflow and undefined
//   opcodes are resolved at acceptance and go straight to DONE.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   flush          : kill in-flight or completed operation
//   in_valid/ready : request handshake (ready only while idle)
//   in_op[3:0]     : bit3 = W-op; [2:0] 0 MUL 1 DIV 2 DIVU 3 REM 4 REMU
//   in_a, in_b     : dividend/multiplicand, divisor/multiplier
//   out_valid/ready: result handshake; out_result is held while valid
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;

    // Latched operation and iteration datapath
    logic             op_w, op_mul, op_rem, neg_q, neg_r;
    logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0] opa;   // shifting multiplicand / shifting dividend
    logic [WIDTH-1:0] opb;   // shifting multiplier / divisor magnitude
    logic [WIDTH-1:0] quo;

    // W results keep the low half and sign-extend its top bit
    function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] x, input logic w);
        return w ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
    endfunction

    // ---------------- acceptance decode ----------------
    logic             in_w, in_mul, in_sgn, in_rem, in_defined;
    logic             a_neg, b_neg, b_zero, ovf, special, accept;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, special_result;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        in_w       = in_op[3];
        in_mul     = (in_op[2:0] == 3'd0);
        in_sgn     = (in_op[2:0] == 3'd1) || (in_op[2:0] == 3'd3);
        in_rem     = (in_op[2:0] == 3'd3) || (in_op[2:0] == 3'd4);
        in_defined = (in_op[2:0] <= 3'd4);

        // Operands viewed as N-bit values extended to WIDTH by signedness
        a_ext = in_a;
        b_ext = in_b;
        if (in_w) begin
            a_ext = in_sgn ? fix_w(in_a, 1'b1) : {{HALF{1'b0}}, in_a[HALF-1:0]};
            b_ext = in_sgn ? fix_w(in_b, 1'b1) : {{HALF{1'b0}}, in_b[HALF-1:0]};
        end
        a_neg = in_sgn & a_ext[WIDTH-1];
        b_neg = in_sgn & b_ext[WIDTH-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        min_neg = in_w ? ({WIDTH{1'b1}} << (HALF - 1)) : ({WIDTH{1'b1}} << (WIDTH - 1));
        b_zero  = (b_ext == '0);
        ovf     = in_sgn && (a_ext == min_neg) && (b_ext == '1);
        special = !in_defined || (!in_mul && (b_zero || ovf));

        special_result = '0;
        if (in_defined && !in_mul) begin
            if (b_zero)
                special_result = in_rem ? fix_w(in_a, in_w) : '1;
            else if (ovf)
                special_result = in_rem ? '0 : fix_w(in_a, in_w);
        end

        accept = (state == IDLE) && in_valid && !flush;
    end

    // ---------------- one iteration ----------------
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n, quo_n, q_signed, r_signed, result_n;

    always_comb begin
        shifted = {acc, opa[WIDTH-1]};
        opa_n   = opa << 1;
        opb_n   = opb;
        quo_n   = quo;
        acc_n   = acc;
        if (op_mul) begin
            acc_n = acc + (opb[0] ? opa : '0);
            opb_n = opb >> 1;
        end else if (shifted >= {1'b0, opb}) begin
            acc_n = WIDTH'(shifted - {1'b0, opb});
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end

        q_signed = neg_q ? -quo_n : quo_n;
        r_signed = neg_r ? -acc_n : acc_n;
        if (op_mul)
            result_n = fix_w(acc_n, op_w);
        else
            result_n = fix_w(op_rem ? r_signed : q_signed, op_w);
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)              state_next = special ? DONE : BUSY;
            BUSY: if (cnt == CW'(1))       state_next = DONE;
            DONE: if (out_ready)           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Counter and result register: reset to known values
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            out_result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= special ? '0 : (in_w ? CW'(HALF) : CW'(WIDTH));
            if (special) out_result <= special_result;
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) out_result <= result_n;
        end
    end

    // NOTE: datapath registers are not reset; they are always loaded on
    // acceptance before being read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_w   <= in_w;
            op_mul <= in_mul;
            op_rem <= in_rem;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc    <= '0;
            quo    <= '0;
            if (in_mul) begin
                opa <= in_a;
                opb <= in_b;
            end else begin
                // W dividends sit in the upper half so the top bit shifts out first
                opa <= in_w ? (a_mag << HALF) : a_mag;
                opb <= b_mag;
            end
        end else if (state == BUSY) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            quo <= quo_n;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (WIDTH=64). The driver pushes the expected
//   result and latency of every accepted operation; a monitor pops on the
//   first cycle of out_valid and checks value, latency and stability while held.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;

    logic bp_mode    = 1'b0;
    logic hold_ready = 1'b1;
    logic rnd_ready  = 1'b1;
    assign out_ready = bp_mode ? rnd_ready : hold_ready;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rnd_ready = ($urandom_range(0, 2) != 0);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic        w;
        longint      sa, sb, smin;
        logic [63:0] ua, ub, r;
        w    = op[3];
        ua   = w ? {32'h0, a[31:0]} : a;
        ub   = w ? {32'h0, b[31:0]} : b;
        sa   = w ? longint'(sx32(a)) : longint'(a);
        sb   = w ? longint'(sx32(b)) : longint'(b);
        smin = w ? longint'(64'hFFFF_FFFF_8000_0000) : longint'(64'h8000_0000_0000_0000);
        r    = 64'h0;
        case (op[2:0])
            3'd0: r = a * b;
            3'd1: begin
                if (sb == 0)                     r = 64'hFFFF_FFFF_FFFF_FFFF;
                else if (sa == smin && sb == -1) r = sa;
                else                             r = sa / sb;
            end
            3'd2: r = (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ua / ub;
            3'd3: begin
                if (sb == 0)                     r = sa;
                else if (sa == smin && sb == -1) r = 64'h0;
                else                             r = sa % sb;
            end
            3'd4: r = (ub == 0) ? ua : ua % ub;
            default: r = 64'h0;
        endcase
        return w ? sx32(r) : r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic   w, sgn, zero, ovf;
        longint sa, sb, smin;
        w    = op[3];
        sgn  = (op[2:0] == 3'd1) || (op[2:0] == 3'd3);
        sa   = w ? longint'(sx32(a)) : longint'(a);
        sb   = w ? longint'(sx32(b)) : longint'(b);
        smin = w ? longint'(64'hFFFF_FFFF_8000_0000) : longint'(64'h8000_0000_0000_0000);
        zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf  = sgn && sa == smin && sb == -1;
        if (op[2:0] > 3'd4)                       return 1;
        if (op[2:0] != 3'd0 && (zero || ovf))     return 1;
        return w ? 33 : 65;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] exp;
        int          k;
        int          lat;
        logic [3:0]  op;
    } txn_t;

    txn_t sb[$];
    txn_t cur;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (out_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h with empty scoreboard (cycle %0d)", out_result, cyc);
            end else begin
                cur = sb.pop_front();
                check($sformatf("result op=%0d", cur.op), out_result, cur.exp);
                check($sformatf("latency op=%0d", cur.op), 64'(cyc - cur.k), 64'(cur.lat));
            end
        end else if (out_valid === 1'b1 && prev_valid) begin
            check($sformatf("held_result op=%0d", cur.op), out_result, cur.exp);
        end
        prev_valid = (out_valid === 1'b1);
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
        int   guard;
        txn_t t;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            fail("issue_wait_in_ready");
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        t.exp = exp; t.k = cyc; t.lat = lat; t.op = op;
        sb.push_back(t);
        @(negedge clk);
        // Scramble the operand bus: the unit must have latched its inputs
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
    endtask

    task automatic issue_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        issue(op, a, b, ref_result(op, a, b), ref_lat(op, a, b));
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) fail(name);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b;
        int          guard;
        logic        seen;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_in_ready",   64'(in_ready),  64'd1);
        check("reset_out_valid",  64'(out_valid), 64'd0);
        check("reset_out_result", out_result,     64'd0);

        // Directed cases with expected values taken straight from arithmetic
        issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        issue(4'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        issue(4'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        issue(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 65);
        issue(4'd2,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue(4'd4,  64'h1234, 64'd0, 64'h1234, 1);
        issue(4'd10, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        issue(4'd9,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        issue(4'd11, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        issue(4'd6,  64'h55, 64'h3, 64'h0, 1);
        drain("drain_directed");

        // Backpressure: hold out_ready low for 5 valid cycles
        hold_ready = 1'b0;
        issue(4'd0, 64'h1_0000_0003, 64'h5, 64'h5_0000_000F, 65);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (out_valid !== 1'b1) fail("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            if (i == 2) begin
                in_valid = 1'b1;
                in_op    = 4'd2;
                in_a     = 64'h99;
                in_b     = 64'h0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid   = 1'b0;
        hold_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        repeat (3) @(negedge clk);
        check("bp_pulse_ignored", 64'(out_valid), 64'd0);

        // Flush in the 10th BUSY cycle of a DIV
        issue(4'd1, 64'd1000, 64'd7, 64'd142, 65);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        issue(4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        drain("drain_flush");

        // Reset in the middle of a BUSY DIV
        issue(4'd3, 64'd1000, 64'd7, 64'd6, 65);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        check("midreset_in_ready",   64'(in_ready),  64'd1);
        check("midreset_out_valid",  64'(out_valid), 64'd0);
        check("midreset_out_result", out_result,     64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("midreset_no_result", 64'(seen), 64'd0);

        // Randomised operations with random output backpressure
        bp_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ;
                1: b = op[3] ? {b[63:32], 32'h0} : 64'h0;
                2: begin
                    a = op[3] ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = op[3] ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3: begin
                    a = 64'($urandom_range(0, 1000));
                    b = 64'($urandom_range(1, 50));
                end
                4: b = -64'($urandom_range(1, 100));
                default: a = -64'($urandom_range(1, 100000));
            endcase
            issue_ref(op, a, b);
        end
        drain("drain_random");
        bp_mode = 1'b0;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
